// File: rtl/seq_exec_unit.sv
// seq_exec_unit: single-issue ALU/branch unit plus an iterative
// one-bit-per-cycle multiplier/divider behind a valid/ready handshake.
module seq_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] Operand1,
  input  logic [XLEN-1:0] Operand2,
  input  logic [5:0]      Operation,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Out,
  output logic            bcond
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d, a_q, a_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d, aneg_q, aneg_d;
  logic            div0_q, div0_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            bc_q, bc_d;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign Out       = out_q;
  assign bcond     = bc_q;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    sum, alu_out;
  logic               alu_bc, lt_s, lt_u;

  assign shamt = Operand2[SHAMT_W-1:0];
  assign sum   = Operand1 + Operand2;
  assign lt_s  = $signed(Operand1) < $signed(Operand2);
  assign lt_u  = Operand1 < Operand2;

  always_comb begin
    alu_out = '0;
    alu_bc  = 1'b0;
    if (!Operation[4]) begin
      case (Operation[3:0])
        4'b0000: alu_out = sum;
        4'b1000: alu_out = Operand1 - Operand2;
        4'b0001: alu_out = Operand1 << shamt;
        4'b0010: alu_out = {{(XLEN-1){1'b0}}, lt_s};
        4'b0011: alu_out = {{(XLEN-1){1'b0}}, lt_u};
        4'b0100: alu_out = Operand1 ^ Operand2;
        4'b0101: alu_out = Operand1 >> shamt;
        4'b1101: alu_out = $unsigned($signed(Operand1) >>> shamt);
        4'b0110: alu_out = Operand1 | Operand2;
        4'b0111: alu_out = Operand1 & Operand2;
        default: alu_out = '0;
      endcase
    end else begin
      case (Operation[3:0])
        4'b0000: alu_bc  = (Operand1 == Operand2);
        4'b0001: alu_bc  = (Operand1 != Operand2);
        4'b0100: alu_bc  = lt_s;
        4'b0101: alu_bc  = !lt_s;
        4'b0110: alu_bc  = lt_u;
        4'b0111: alu_bc  = !lt_u;
        4'b1001: alu_out = {sum[XLEN-1:1], 1'b0};
        4'b1000: alu_out = Operand2;
        default: alu_bc  = 1'b0;
      endcase
    end
  end

  // Mul/div run on magnitudes; signs are reapplied when finishing.
  logic            md_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign md_div = Operation[2];
  assign a_sgn  = md_div ? !Operation[0]
                         : (Operation[1:0] == 2'b01) || (Operation[1:0] == 2'b10);
  assign b_sgn  = md_div ? !Operation[0] : (Operation[1:0] == 2'b01);
  assign a_neg  = a_sgn && Operand1[XLEN-1];
  assign b_neg  = b_sgn && Operand2[XLEN-1];
  assign a_mag  = a_neg ? -Operand1 : Operand1;
  assign b_mag  = b_neg ? -Operand2 : Operand2;

  logic [XLEN:0]     msum, rsh, diff;
  logic [XLEN-1:0]   mhi, mlo, dhi, dlo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mres, quo, rem, dres;

  assign msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign mhi    = msum[XLEN:1];
  assign mlo    = {msum[0], lo_q[XLEN-1:1]};
  assign rsh    = {hi_q, lo_q[XLEN-1]};
  assign diff   = rsh - {1'b0, b_q};
  assign dhi    = diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0];
  assign dlo    = {lo_q[XLEN-2:0], !diff[XLEN]};
  assign prod   = {mhi, mlo};
  assign prod_s = neg_q ? -prod : prod;
  assign mres   = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                       : prod_s[2*XLEN-1:XLEN];
  assign quo    = div0_q ? '1   : (neg_q  ? -dlo : dlo);
  assign rem    = div0_q ? a_q  : (aneg_q ? -dhi : dhi);
  assign dres   = op_q[1] ? rem : quo;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    a_d     = a_q;
    op_d    = op_q;
    neg_d   = neg_q;
    aneg_d  = aneg_q;
    div0_d  = div0_q;
    out_d   = out_q;
    bc_d    = bc_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (Operation[5]) begin
            state_d = BUSY;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = md_div ? a_mag : b_mag;
            b_d     = md_div ? b_mag : a_mag;
            a_d     = Operand1;
            op_d    = Operation[2:0];
            neg_d   = a_neg ^ b_neg;
            aneg_d  = a_neg;
            div0_d  = (Operand2 == '0);
          end else begin
            state_d = DONE;
            out_d   = alu_out;
            bc_d    = alu_bc;
          end
        end
      end
      BUSY: begin
        hi_d  = op_q[2] ? dhi : mhi;
        lo_d  = op_q[2] ? dlo : mlo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = DONE;
          out_d   = op_q[2] ? dres : mres;
          bc_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      a_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      aneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      out_q   <= '0;
      bc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      a_q     <= a_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      aneg_q  <= aneg_d;
      div0_q  <= div0_d;
      out_q   <= out_d;
      bc_q    <= bc_d;
    end
  end
endmodule

// File: tb/tb_seq_exec_unit.sv
// tb_seq_exec_unit: directed and randomized checks of seq_exec_unit
// against a plain-arithmetic reference model.
module tb_seq_exec_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [5:0]  Operation = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] Out;
  logic        bcond;

  int checks = 0;
  int passes = 0;

  seq_exec_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Operand1(Operand1), .Operand2(Operand2), .Operation(Operation),
    .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .bcond(bcond)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [5:0] op,
                                input logic [31:0] a, b,
                                output logic [31:0] o,
                                output logic bc, output int lat);
    int sa, sb;
    longint p;
    logic [63:0] up;
    logic ovf;
    sa = a;
    sb = b;
    o = '0;
    bc = 1'b0;
    lat = op[5] ? 33 : 1;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (op[5]) begin
      case (op[2:0])
        3'd0: o = a * b;
        3'd1: begin p = longint'(sa) * longint'(sb); o = p[63:32]; end
        3'd2: begin p = longint'(sa) * longint'({32'b0, b}); o = p[63:32]; end
        3'd3: begin up = {32'b0, a} * {32'b0, b}; o = up[63:32]; end
        3'd4: o = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
        3'd5: o = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: o = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
        default: o = (b == 0) ? a : a % b;
      endcase
    end else if (!op[4]) begin
      case (op[3:0])
        4'b0000: o = a + b;
        4'b1000: o = a - b;
        4'b0001: o = a << b[4:0];
        4'b0010: o = (sa < sb) ? 32'd1 : 32'd0;
        4'b0011: o = (a < b) ? 32'd1 : 32'd0;
        4'b0100: o = a ^ b;
        4'b0101: o = a >> b[4:0];
        4'b1101: o = 32'(sa >>> b[4:0]);
        4'b0110: o = a | b;
        4'b0111: o = a & b;
        default: o = '0;
      endcase
    end else begin
      case (op[3:0])
        4'b0000: bc = (a == b);
        4'b0001: bc = (a != b);
        4'b0100: bc = (sa < sb);
        4'b0101: bc = (sa >= sb);
        4'b0110: bc = (a < b);
        4'b0111: bc = (a >= b);
        4'b1001: o = (a + b) & 32'hFFFF_FFFE;
        4'b1000: o = b;
        default: o = '0;
      endcase
    end
  endfunction

  // Called at a negedge with out_ready=1; returns at a negedge after
  // the result has been taken.
  task automatic drive(input logic [5:0] op, input logic [31:0] a, b,
                       output logic [31:0] o, output logic bc,
                       output int lat, output logic rdy);
    Operation = op;
    Operand1  = a;
    Operand2  = b;
    in_valid  = 1'b1;
    rdy = in_ready;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    Operand1  = $urandom;
    Operand2  = $urandom;
    Operation = 6'($urandom);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    o  = Out;
    bc = bcond;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || Out !== 32'h0 || bcond !== 1'b0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b Out=%h bcond=%b, need 0 0 0 0",
               in_ready, out_valid, Out, bcond);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%b need 1", in_ready);
    else passes++;
  endtask

  task automatic test_directed();
    logic [5:0]  op [16] = '{6'b000000, 6'b010100, 6'b010110, 6'b011001,
                            6'b100011, 6'b100001, 6'b100000, 6'b100100,
                            6'b100110, 6'b100101, 6'b100111, 6'b100100,
                            6'b100110, 6'b001101, 6'b011000, 6'b001111};
    logic [31:0] a  [16] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1001,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                            32'h8000_0000, 32'd7, 32'd7, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'h8000_0000, 32'h0, 32'h5};
    logic [31:0] b  [16] = '{32'h1, 32'h1, 32'h1, 32'h2,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'h0, 32'h0, 32'h2,
                            32'h2, 32'h24, 32'hABCD_E000, 32'h3};
    logic [31:0] eo [16] = '{32'h8000_0000, 32'h0, 32'h0, 32'h1002,
                            32'hFFFF_FFFE, 32'h0, 32'h1, 32'h8000_0000,
                            32'h0, 32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFFD,
                            32'hFFFF_FFFF, 32'hF800_0000, 32'hABCD_E000, 32'h0};
    logic        eb [16] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int          el [16] = '{1, 1, 1, 1, 33, 33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1};
    logic [31:0] o;
    logic bc, rdy;
    int lat;
    for (int i = 0; i < 16; i++) begin
      drive(op[i], a[i], b[i], o, bc, lat, rdy);
      checks++;
      if (o !== eo[i] || bc !== eb[i] || lat != el[i] || rdy !== 1'b1 || in_ready !== 1'b1)
        $display("FAIL directed_%0d op=%b: Out=%h bcond=%b lat=%0d acc=%b rdy_after=%b, need %h %b %0d 1 1",
                 i, op[i], o, bc, lat, rdy, in_ready, eo[i], eb[i], el[i]);
      else passes++;
    end
  endtask

  task automatic test_random_alu();
    logic [5:0] codes [17] = '{6'h00, 6'h08, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                              6'h0D, 6'h06, 6'h07, 6'h10, 6'h11, 6'h14, 6'h15,
                              6'h16, 6'h17, 6'h19};
    logic [5:0] op;
    logic [31:0] a, b, o, eo;
    logic bc, eb, rdy;
    int lat, el;
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 7) == 0) ? {1'b0, 5'($urandom)}
                                       : codes[$urandom_range(0, 16)];
      a = pick();
      b = pick();
      model(op, a, b, eo, eb, el);
      drive(op, a, b, o, bc, lat, rdy);
      checks++;
      if (o !== eo || bc !== eb || lat != el || rdy !== 1'b1)
        $display("FAIL rand_alu op=%b a=%h b=%h: Out=%h bcond=%b lat=%0d, need %h %b %0d",
                 op, a, b, o, bc, lat, eo, eb, el);
      else passes++;
    end
  endtask

  task automatic test_random_muldiv();
    logic [5:0] op;
    logic [31:0] a, b, o, eo;
    logic bc, eb, rdy;
    int lat, el;
    for (int i = 0; i < 60; i++) begin
      op = {1'b1, 2'($urandom), 3'($urandom)};
      a = pick();
      b = pick();
      model(op, a, b, eo, eb, el);
      drive(op, a, b, o, bc, lat, rdy);
      checks++;
      if (o !== eo || bc !== eb || lat != el || rdy !== 1'b1)
        $display("FAIL rand_md op=%b a=%h b=%h: Out=%h bcond=%b lat=%0d, need %h %b %0d",
                 op, a, b, o, bc, lat, eo, eb, el);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    out_ready = 1'b0;
    Operation = 6'b000000;
    Operand1  = 32'd3;
    Operand2  = 32'd4;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || Out !== 32'd7 || in_ready !== 1'b0) ok = 1'b0;
      Operation = 6'b001000;
      Operand1  = 32'd100 + 32'(i);
      Operand2  = 32'd1;
      in_valid  = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!ok || out_valid !== 1'b1 || Out !== 32'd7)
      $display("FAIL hold_done: out_valid=%b Out=%h, need 1 00000007 stable with in_ready 0",
               out_valid, Out);
    else passes++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL release: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || Out !== 32'd7)
      $display("FAIL single_xfer: out_valid=%b Out=%h, need 0 00000007", out_valid, Out);
    else passes++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] o;
    logic bc, rdy, seen;
    int lat;
    Operation = 6'b100100;
    Operand1  = 32'd100;
    Operand2  = 32'd7;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || Out !== 32'h0 || bcond !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL abort_rst: out_valid=%b Out=%h bcond=%b in_ready=%b, need 0 0 0 0",
               out_valid, Out, bcond, in_ready);
    else passes++;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || in_ready !== 1'b1)
      $display("FAIL abort_quiet: stray_valid=%b in_ready=%b, need 0 1", seen, in_ready);
    else passes++;
    drive(6'b001000, 32'd5, 32'd7, o, bc, lat, rdy);
    checks++;
    if (o !== 32'hFFFF_FFFE || bc !== 1'b0 || lat != 1 || rdy !== 1'b1)
      $display("FAIL abort_sub: Out=%h bcond=%b lat=%0d, need FFFFFFFE 0 1", o, bc, lat);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_alu();
    test_random_muldiv();
    test_backpressure();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
